// File: rtl/imm_ext_pkg.sv
// Shared mode encoding, opcode constants and decode helper for the immediate extender.
package imm_ext_pkg;

    typedef enum logic [1:0] {
        MODE_SIGN   = 2'd0,
        MODE_ZERO   = 2'd1,
        MODE_UPPER  = 2'd2,
        MODE_BRANCH = 2'd3
    } imm_mode_e;

    localparam int unsigned OPC_BEQ  = 32'h04;
    localparam int unsigned OPC_BNE  = 32'h05;
    localparam int unsigned OPC_ANDI = 32'h0C;
    localparam int unsigned OPC_ORI  = 32'h0D;
    localparam int unsigned OPC_XORI = 32'h0E;
    localparam int unsigned OPC_LUI  = 32'h0F;

    function automatic imm_mode_e decode_mode(input int unsigned opc);
        imm_mode_e m;
        case (opc)
            OPC_ANDI, OPC_ORI, OPC_XORI: m = MODE_ZERO;
            OPC_LUI:                     m = MODE_UPPER;
            OPC_BEQ, OPC_BNE:            m = MODE_BRANCH;
            default:                     m = MODE_SIGN;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/imm_ext_if.sv
// Request/result handshake bundle for the immediate extension pipe.
interface imm_ext_if
    import imm_ext_pkg::*;
#(
    parameter int IMM_W  = 16,
    parameter int DATA_W = 32,
    parameter int OPC_W  = 6
) ();

    logic              in_valid;
    logic              in_ready;
    logic [OPC_W-1:0]  in_opcode;
    logic [IMM_W-1:0]  in_imm;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_imm;
    imm_mode_e         out_mode;

    modport master (
        output in_valid, in_opcode, in_imm, out_ready,
        input  in_ready, out_valid, out_imm, out_mode
    );

    modport slave (
        input  in_valid, in_opcode, in_imm, out_ready,
        output in_ready, out_valid, out_imm, out_mode
    );

endinterface

// File: rtl/imm_ext_core.sv
// Combinational opcode decode and immediate extension.
module imm_ext_core
    import imm_ext_pkg::*;
#(
    parameter int IMM_W  = 16,
    parameter int DATA_W = 32,
    parameter int OPC_W  = 6
) (
    input  logic [OPC_W-1:0]  in_opcode,
    input  logic [IMM_W-1:0]  in_imm,
    output imm_mode_e         mode,
    output logic [DATA_W-1:0] result
);

    logic [DATA_W-1:0] sext;

    assign sext = {{(DATA_W-IMM_W){in_imm[IMM_W-1]}}, in_imm};
    assign mode = decode_mode(32'(in_opcode));

    always_comb begin
        result = sext;
        case (mode)
            MODE_ZERO:   result = {{(DATA_W-IMM_W){1'b0}}, in_imm};
            MODE_UPPER:  result = {in_imm, {(DATA_W-IMM_W){1'b0}}};
            // Word offset: top two sign bits fall off the end.
            MODE_BRANCH: result = sext << 2;
            default:     result = sext;
        endcase
    end

endmodule

// File: rtl/imm_ext_pipe.sv
// Latency-1 immediate extender with an output register plus one skid entry.
module imm_ext_pipe
    import imm_ext_pkg::*;
#(
    parameter int IMM_W  = 16,
    parameter int DATA_W = 32,
    parameter int OPC_W  = 6
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     flush,
    imm_ext_if.slave bus
);

    logic              out_vld;
    logic              skid_vld;
    logic              rdy;
    logic [DATA_W-1:0] out_q;
    logic [DATA_W-1:0] skid_q;
    imm_mode_e         out_m;
    imm_mode_e         skid_m;
    logic [DATA_W-1:0] core_imm;
    imm_mode_e         core_mode;
    logic              accept;
    logic              drain;

    imm_ext_core #(
        .IMM_W (IMM_W),
        .DATA_W(DATA_W),
        .OPC_W (OPC_W)
    ) u_core (
        .in_opcode(bus.in_opcode),
        .in_imm   (bus.in_imm),
        .mode     (core_mode),
        .result   (core_imm)
    );

    assign accept = bus.in_valid && rdy && !flush;
    assign drain  = out_vld && bus.out_ready;

    // rdy tracks !skid_vld but is held low through reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_vld  <= 1'b0;
            skid_vld <= 1'b0;
            rdy      <= 1'b0;
            out_q    <= '0;
            skid_q   <= '0;
            out_m    <= MODE_SIGN;
            skid_m   <= MODE_SIGN;
        end else if (flush) begin
            out_vld  <= 1'b0;
            skid_vld <= 1'b0;
            rdy      <= 1'b1;
        end else if (skid_vld) begin
            rdy <= drain;
            if (drain) begin
                out_q    <= skid_q;
                out_m    <= skid_m;
                skid_vld <= 1'b0;
            end
        end else if (accept) begin
            if (!out_vld || bus.out_ready) begin
                out_q   <= core_imm;
                out_m   <= core_mode;
                out_vld <= 1'b1;
                rdy     <= 1'b1;
            end else begin
                skid_q   <= core_imm;
                skid_m   <= core_mode;
                skid_vld <= 1'b1;
                rdy      <= 1'b0;
            end
        end else begin
            rdy <= 1'b1;
            if (drain) out_vld <= 1'b0;
        end
    end

    assign bus.in_ready  = rdy;
    assign bus.out_valid = out_vld;
    assign bus.out_imm   = out_q;
    assign bus.out_mode  = out_m;

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Scoreboard bench for imm_ext_pipe: directed vectors, backpressure, flush, reset, random traffic.
module tb_imm_ext_pipe;

    typedef struct packed {
        logic [31:0] imm;
        logic [1:0]  mode;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    int   checks = 0;
    int   errors = 0;
    exp_t q[$];
    bit   stop_rand = 1'b0;

    imm_ext_if #(.IMM_W(16), .DATA_W(32), .OPC_W(6)) bus ();

    imm_ext_pipe #(.IMM_W(16), .DATA_W(32), .OPC_W(6)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .flush(flush),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [5:0] opc, input logic [15:0] imm);
        exp_t e;
        int   s;
        s = int'($signed(imm));
        case (opc)
            6'h0C, 6'h0D, 6'h0E: begin e.mode = 2'd1; e.imm = {16'h0000, imm}; end
            6'h0F:               begin e.mode = 2'd2; e.imm = {imm, 16'h0000}; end
            6'h04, 6'h05:        begin e.mode = 2'd3; e.imm = 32'(s * 4); end
            default:             begin e.mode = 2'd0; e.imm = 32'(s); end
        endcase
        return e;
    endfunction

    // Called at posedge+1; returns at posedge+1 after the request is taken.
    task automatic push(input logic [5:0] opc, input logic [15:0] imm, input exp_t e);
        int n = 0;
        bus.in_valid  = 1'b1;
        bus.in_opcode = opc;
        bus.in_imm    = imm;
        @(negedge clk);
        while (!bus.in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (bus.in_ready) q.push_back(e);
        else chk("push_timeout", 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (bus.out_valid && bus.out_ready) begin
            chk("sb_empty_on_out", 64'(q.size() == 0), 64'd0);
            if (q.size() != 0) begin
                exp_t e;
                e = q.pop_front();
                chk("out_imm", 64'(bus.out_imm), 64'(e.imm));
                chk("out_mode", 64'(bus.out_mode), 64'(e.mode));
            end
        end
    end

    function automatic exp_t mk(input logic [31:0] imm, input logic [1:0] mode);
        exp_t e;
        e.imm  = imm;
        e.mode = mode;
        return e;
    endfunction

    initial begin
        logic [5:0] opcs [10];
        exp_t       ea;
        opcs = '{6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h04, 6'h05, 6'h23, 6'h00, 6'h3F, 6'h08};
        bus.in_valid  = 1'b0;
        bus.in_opcode = '0;
        bus.in_imm    = '0;
        bus.out_ready = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_imm", 64'(bus.out_imm), 64'd0);
        chk("rst_out_mode", 64'(bus.out_mode), 64'd0);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        #1;

        // Directed vectors, consumer always ready
        bus.out_ready = 1'b1;
        push(6'h0C, 16'h8001, mk(32'h0000_8001, 2'd1));
        @(negedge clk);
        chk("latency1_valid", 64'(bus.out_valid), 64'd1);
        @(posedge clk);
        #1;
        push(6'h0F, 16'h1234, mk(32'h1234_0000, 2'd2));
        push(6'h23, 16'hFFFC, mk(32'hFFFF_FFFC, 2'd0));
        push(6'h04, 16'hFFFF, mk(32'hFFFF_FFFC, 2'd3));
        push(6'h05, 16'h0003, mk(32'h0000_000C, 2'd3));
        push(6'h0E, 16'hFFFF, mk(32'h0000_FFFF, 2'd1));
        push(6'h04, 16'h7FFF, mk(32'h0001_FFFC, 2'd3));
        repeat (2) @(posedge clk);
        #1;

        // Backpressure: A to output, B to skid, C held until drain
        bus.out_ready = 1'b0;
        ea = mk(32'h0000_0011, 2'd0);
        push(6'h08, 16'h0011, ea);
        push(6'h0D, 16'h0022, mk(32'h0000_0022, 2'd1));
        fork
            push(6'h0F, 16'h0033, mk(32'h0033_0000, 2'd2));
            begin
                repeat (3) begin
                    @(negedge clk);
                    chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
                    chk("bp_hold_imm", 64'(bus.out_imm), 64'(ea.imm));
                    chk("bp_hold_valid", 64'(bus.out_valid), 64'd1);
                end
                @(posedge clk);
                #1;
                bus.out_ready = 1'b1;
                repeat (3) begin
                    @(negedge clk);
                    chk("bp_no_gap", 64'(bus.out_valid), 64'd1);
                end
            end
        join
        repeat (3) @(posedge clk);
        #1;
        chk("bp_drained", 64'(q.size()), 64'd0);

        // Flush with output and skid both full
        bus.out_ready = 1'b0;
        push(6'h01, 16'h0101, mk(32'h0000_0101, 2'd0));
        push(6'h02, 16'h0202, mk(32'h0000_0202, 2'd0));
        flush = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_opcode = 6'h03;
        bus.in_imm = 16'h0303;
        @(posedge clk);
        #1;
        flush = 1'b0;
        bus.in_valid = 1'b0;
        q.delete();
        @(negedge clk);
        chk("flush_out_valid", 64'(bus.out_valid), 64'd0);
        chk("flush_in_ready", 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        #1;
        // Request offered with in_ready high during a flush must vanish
        flush = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_opcode = 6'h0F;
        bus.in_imm = 16'hBEEF;
        @(posedge clk);
        #1;
        flush = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("flush_drop", 64'(bus.out_valid), 64'd0);
        end
        @(posedge clk);
        #1;

        // Reset mid-stream with skid full
        bus.out_ready = 1'b0;
        push(6'h0C, 16'h0AAA, mk(32'h0000_0AAA, 2'd1));
        push(6'h0C, 16'h0BBB, mk(32'h0000_0BBB, 2'd1));
        rst_n = 1'b0;
        flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("mid_rst_out_imm", 64'(bus.out_imm), 64'd0);
        chk("mid_rst_in_ready", 64'(bus.in_ready), 64'd0);
        q.delete();
        rst_n = 1'b1;
        flush = 1'b0;
        @(negedge clk);
        chk("mid_rst_in_ready_after", 64'(bus.in_ready), 64'd1);
        chk("mid_rst_no_out", 64'(bus.out_valid), 64'd0);
        @(posedge clk);
        #1;

        // Random traffic under random backpressure
        fork
            begin
                while (!stop_rand) begin
                    @(posedge clk);
                    #1;
                    bus.out_ready = ($urandom_range(0, 2) != 0);
                end
            end
            begin
                for (int i = 0; i < 200; i++) begin
                    logic [5:0]  o;
                    logic [15:0] im;
                    o  = ($urandom_range(0, 3) == 0) ? 6'($urandom) : opcs[$urandom_range(0, 9)];
                    im = 16'($urandom);
                    push(o, im, model(o, im));
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk);
                        #1;
                    end
                end
                stop_rand = 1'b1;
            end
        join
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        for (int n = 0; n < 50 && q.size() != 0; n++) @(posedge clk);
        @(negedge clk);
        chk("final_drained", 64'(q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/imm_ext_pipe.md
IMM_EXT_PIPE -- requirements
Module: imm_ext_pipe

Interface
REQ-001 SHALL have parameter IMM_W, default 16, meaning raw immediate field width.
REQ-002 SHALL have parameter DATA_W, default 32, meaning extended result width; legal only when DATA_W >= IMM_W+2.
REQ-003 SHALL have parameter OPC_W, default 6, meaning opcode width.
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port flush  input  1  synchronous pipeline kill.
REQ-007 SHALL have port in_valid  input  1  request present.
REQ-008 SHALL have port in_ready  output  1  request accepted when in_valid&&in_ready.
REQ-009 SHALL have port in_opcode  input  OPC_W  instruction opcode.
REQ-010 SHALL have port in_imm  input  IMM_W  raw immediate field.
REQ-011 SHALL have port out_valid  output  1  result present.
REQ-012 SHALL have port out_ready  input  1  consumer accepts when out_valid&&out_ready.
REQ-013 SHALL have port out_imm  output  DATA_W  extended immediate.
REQ-014 SHALL have port out_mode  output  2  mode applied (SIGN=0, ZERO=1, UPPER=2, BRANCH=3).

Function
REQ-015 Mode decode SHALL be: opcode 0x0C/0x0D/0x0E (andi/ori/xori) -> ZERO; 0x0F (lui) -> UPPER; 0x04/0x05 (beq/bne) -> BRANCH; all others -> SIGN.
REQ-016 SIGN SHALL replicate in_imm[IMM_W-1] into bits DATA_W-1..IMM_W.
REQ-017 ZERO SHALL fill bits DATA_W-1..IMM_W with 0.
REQ-018 UPPER SHALL place in_imm in bits DATA_W-1..DATA_W-IMM_W, zeros below.
REQ-019 BRANCH SHALL sign-extend then shift left 2, bits 1..0 = 0, top bits truncated.
REQ-020 Result SHALL appear on out_imm/out_mode with out_valid high on the cycle after acceptance (latency 1) when the output register is free or draining.
REQ-021 Storage SHALL be one output register plus one skid register; in_ready SHALL equal !skid_valid (registered, no combinational path from out_ready).
REQ-022 Accept when output register empty or draining (out_ready high) SHALL load output register directly.
REQ-023 Accept while output register holds and out_ready low SHALL load skid register.
REQ-024 Drain with skid valid SHALL move skid into output register same edge; a simultaneous accept SHALL then go to skid; order SHALL be strictly FIFO.
REQ-025 While out_valid && !out_ready, out_imm and out_mode SHALL remain stable.
REQ-026 flush SHALL clear out_valid and skid_valid on the next edge; a request presented during a flush cycle SHALL be dropped; flush SHALL override simultaneous accept/drain.
REQ-027 No request SHALL be lost or duplicated under any out_ready pattern.

Reset
REQ-028 While rst_n low at a rising edge: out_valid=0, skid_valid=0, out_imm=0, out_mode=SIGN.
REQ-029 in_ready SHALL be 0 while rst_n is low and 1 on the first cycle after release.
REQ-030 Reset mid-stream SHALL discard all held results; rst_n takes priority over flush.

Structure
REQ-031 Mode encoding, opcode constants (ANDI, ORI, XORI, LUI, BEQ, BNE) SHALL live in shared package imm_ext_pkg.
REQ-032 Decode plus extension SHALL be a combinational sub-module imm_ext_core (in_opcode, in_imm -> mode, result); imm_ext_pipe holds handshake and storage only.

Verification
REQ-033 opcode 0x0C, imm 0x8001, out_ready=1 -> next cycle out_imm=0x00008001, out_mode=ZERO.
REQ-034 opcode 0x0F imm 0x1234 -> 0x12340000 UPPER; opcode 0x23 imm 0xFFFC -> 0xFFFFFFFC SIGN.
REQ-035 opcode 0x04 imm 0xFFFF -> 0xFFFFFFFC BRANCH; imm 0x0003 -> 0x0000000C.
REQ-036 out_ready low, push A,B,C back-to-back -> in_ready 0 after B accepted, C held; out_ready high -> outputs A,B,C in order, one per cycle, no gaps.
REQ-037 Output and skid both full, flush pulse -> next cycle out_valid=0, in_ready=1; a request in the flush cycle never emerges.
REQ-038 rst_n low for one cycle with skid full -> out_valid=0, out_imm=0, in_ready=0 during reset, 1 after.
